sp_queue: RTL and testbench

//   Sorted priority queue for 8-bit keys. Elements are held in a sorted register

---
 rtl/sp_queue.sv | 91 +++++++++
 tb/tb_sp_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sp_queue.sv
// Sorted max-priority queue: a descending register array where q[0] always holds
// the largest stored key. Insert and remove each complete in a single cycle.
module sp_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enqueue_sig,
   input  logic             dequeue_sig,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow
);

   logic [WIDTH-1:0] q_reg  [DEPTH];
   logic [WIDTH-1:0] base_w [DEPTH];
   logic [WIDTH-1:0] q_next [DEPTH];
   logic [DEPTH-1:0] ins_w;

   logic [CNT_W-1:0] count_reg, base_cnt, count_next;
   logic [WIDTH-1:0] data_out_reg;
   logic             full_reg, empty_reg;
   logic             out_valid_reg, overflow_reg, underflow_reg;
   logic             deq_ok, enq_ok;

   // A simultaneous dequeue frees a slot, so a full queue can still accept data.
   assign deq_ok     = dequeue_sig && !empty_reg;
   assign enq_ok     = enqueue_sig && (!full_reg || deq_ok);
   assign base_cnt   = count_reg - CNT_W'(deq_ok);
   assign count_next = base_cnt + CNT_W'(enq_ok);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         // base_w is the array after the optional dequeue shift; insertion works on it.
         if (gi == DEPTH - 1) begin : g_last
            assign base_w[gi] = deq_ok ? '0 : q_reg[gi];
         end else begin : g_mid
            assign base_w[gi] = deq_ok ? q_reg[gi+1] : q_reg[gi];
         end

         // Strict compare keeps ties in arrival order; empty slots always qualify.
         assign ins_w[gi] = (CNT_W'(gi) >= base_cnt) || (data_in > base_w[gi]);

         if (gi == 0) begin : g_head
            assign q_next[gi] = (enq_ok && ins_w[gi]) ? data_in : base_w[gi];
         end else begin : g_tail
            assign q_next[gi] = !(enq_ok && ins_w[gi]) ? base_w[gi] :
                                (ins_w[gi-1] ? base_w[gi-1] : data_in);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         data_out_reg  <= '0;
         out_valid_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
         count_reg     <= count_next;
         full_reg      <= (count_next == CNT_W'(DEPTH));
         empty_reg     <= (count_next == '0);
         if (deq_ok) data_out_reg <= q_reg[0];
         out_valid_reg <= deq_ok;
         overflow_reg  <= enqueue_sig && full_reg && !dequeue_sig;
         underflow_reg <= dequeue_sig && empty_reg;
      end
   end

   assign data_out  = data_out_reg;
   assign out_valid = out_valid_reg;
   assign full      = full_reg;
   assign empty     = empty_reg;
   assign count     = count_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_sp_queue.sv
// Directed bench for sp_queue: linear sequence of single-cycle operations, each
// followed by immediate-assertion checks against hand-computed values.
module tb_sp_queue;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             enqueue_sig;
   logic             dequeue_sig;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             underflow;

   int vectors    = 0;
   int miscompares = 0;

   sp_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .enqueue_sig (enqueue_sig),
      .dequeue_sig (dequeue_sig),
      .data_in     (data_in),
      .data_out    (data_out),
      .out_valid   (out_valid),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of requests, let the edge happen, then release the inputs.
   task automatic cyc(input bit r, input bit e, input bit d, input int v);
      @(negedge clk);
      rst         = r;
      enqueue_sig = e;
      dequeue_sig = d;
      data_in     = WIDTH'(v);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      enqueue_sig = 1'b0;
      dequeue_sig = 1'b0;
      data_in     = '0;
   endtask

   task automatic enq(input int v);
      cyc(1'b0, 1'b1, 1'b0, v);
   endtask

   task automatic deq_expect(input string tag, input int v);
      cyc(1'b0, 1'b0, 1'b1, 0);
      chk(tag, int'(data_out), v);
      chk({tag, "_valid"}, int'(out_valid), 1);
      $display("deq %s -> data_out=%0d count=%0d", tag, data_out, count);
   endtask

   initial begin
      rst = 1'b1; enqueue_sig = 1'b0; dequeue_sig = 1'b0; data_in = '0;
      cyc(1'b1, 1'b0, 1'b0, 0);
      cyc(1'b1, 1'b0, 1'b0, 0);
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_pulses", int'({overflow, underflow}), 0);

      // 1: enqueue 2,2,10,8 then dequeue the maximum
      enq(2); enq(2); enq(10); enq(8);
      chk("t1_count4", int'(count), 4);
      chk("t1_empty0", int'(empty), 0);
      deq_expect("t1_deq10", 10);
      chk("t1_count3", int'(count), 3);
      cyc(1'b0, 1'b0, 1'b0, 0);
      chk("t1_valid_drop", int'(out_valid), 0);
      chk("t1_hold", int'(data_out), 10);

      // 2: contents {8,2,2}; add 6 and 0 then drain
      enq(6); enq(0);
      chk("t2_count5", int'(count), 5);
      deq_expect("t2_deq8", 8);
      deq_expect("t2_deq6", 6);
      chk("t2_count3", int'(count), 3);
      deq_expect("t2_deq2a", 2);
      deq_expect("t2_deq2b", 2);
      deq_expect("t2_deq0", 0);
      chk("t2_empty", int'(empty), 1);
      chk("t2_count0", int'(count), 0);

      // 3: fill 1..8, overflow attempt, ordered drain
      for (int i = 1; i <= DEPTH; i++) enq(i);
      chk("t3_full", int'(full), 1);
      chk("t3_count8", int'(count), 8);
      enq(99);
      chk("t3_overflow", int'(overflow), 1);
      chk("t3_ovf_count", int'(count), 8);
      chk("t3_ovf_full", int'(full), 1);
      cyc(1'b0, 1'b0, 1'b0, 0);
      chk("t3_ovf_drop", int'(overflow), 0);
      for (int i = DEPTH; i >= 1; i--) deq_expect($sformatf("t3_deq%0d", i), i);
      chk("t3_empty", int'(empty), 1);

      // 4: full queue, simultaneous enqueue 50 and dequeue
      for (int i = 1; i <= DEPTH; i++) enq(i);
      cyc(1'b0, 1'b1, 1'b1, 50);
      $display("enq50+deq -> data_out=%0d count=%0d overflow=%0d", data_out, count, overflow);
      chk("t4_data_out", int'(data_out), 8);
      chk("t4_valid", int'(out_valid), 1);
      chk("t4_count8", int'(count), 8);
      chk("t4_no_ovf", int'(overflow), 0);
      chk("t4_full", int'(full), 1);
      deq_expect("t4_deq50", 50);
      for (int i = DEPTH - 1; i >= 1; i--) deq_expect($sformatf("t4_deq%0d", i), i);
      chk("t4_empty", int'(empty), 1);

      // 5: underflow, then enqueue+dequeue on an empty queue
      cyc(1'b0, 1'b0, 1'b1, 0);
      chk("t5_underflow", int'(underflow), 1);
      chk("t5_uf_hold", int'(data_out), 1);
      chk("t5_uf_valid", int'(out_valid), 0);
      cyc(1'b0, 1'b1, 1'b1, 5);
      $display("enq5+deq empty -> count=%0d underflow=%0d", count, underflow);
      chk("t5_ed_count1", int'(count), 1);
      chk("t5_ed_underflow", int'(underflow), 1);
      chk("t5_ed_valid", int'(out_valid), 0);
      chk("t5_ed_hold", int'(data_out), 1);
      chk("t5_ed_empty0", int'(empty), 0);
      deq_expect("t5_deq5", 5);
      chk("t5_uf_drop", int'(underflow), 0);
      chk("t5_empty", int'(empty), 1);

      // 6: reset mid-operation discards contents, and wins over a request
      enq(3); enq(7); enq(4);
      chk("t6_count3", int'(count), 3);
      cyc(1'b1, 1'b1, 1'b1, 9);
      $display("rst mid-op -> count=%0d empty=%0d data_out=%0d", count, empty, data_out);
      chk("t6_count0", int'(count), 0);
      chk("t6_empty", int'(empty), 1);
      chk("t6_data_out0", int'(data_out), 0);
      chk("t6_valid0", int'(out_valid), 0);
      cyc(1'b0, 1'b0, 1'b1, 0);
      chk("t6_post_underflow", int'(underflow), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
